// File: rtl/qspi_flash_arbiter.sv
// Two-requester arbiter in front of the QSPI flash read controller: video has priority,
// general is forced through after pStarveMax video wins. Watchdog under FLASH_ARB_TIMEOUT_EN.
module qspi_flash_arbiter #(
  parameter int pAddrWidth = 24,
  parameter int pLenWidth  = 10,
  parameter int pStarveMax = 64,
  parameter int pTimeout   = 4096
) (
  input  logic                  iSysClk,
  input  logic                  iRst,
  input  logic                  iVidReq,
  input  logic [pAddrWidth-1:0] iVidAddr,
  input  logic [pLenWidth-1:0]  iVidLen,
  input  logic                  iGenReq,
  input  logic [pAddrWidth-1:0] iGenAddr,
  input  logic [pLenWidth-1:0]  iGenLen,
  output logic                  oVidGnt,
  output logic                  oGenGnt,
  output logic                  oFlReq,
  output logic [pAddrWidth-1:0] oFlAddr,
  output logic [pLenWidth-1:0]  oFlLen,
  input  logic                  iFlAck,
  input  logic [7:0]            iFlData,
  input  logic                  iFlValid,
  input  logic                  iFlDone,
  output logic [7:0]            oRdData,
  output logic                  oVidValid,
  output logic                  oGenValid,
  output logic                  oVidDone,
  output logic                  oGenDone,
  output logic                  oFlAbort,
  output logic                  oBusy,
  output logic                  oErr
);

  localparam int CntW    = pLenWidth + 1;
  localparam int StarveW = $clog2(pStarveMax + 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(pStarveMax);

  typedef enum logic [1:0] {IDLE, ISSUE, STREAM, DONE} state_e;

  state_e                 state_q, state_d;
  logic                   owner_gen_q, owner_gen_d;
  logic                   vid_gnt_q, vid_gnt_d, gen_gnt_q, gen_gnt_d;
  logic [pAddrWidth-1:0]  addr_q, addr_d;
  logic [pLenWidth-1:0]   len_q, len_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [StarveW-1:0]     starve_q, starve_d;
  logic [7:0]             rd_data_q, rd_data_d;
  logic                   vid_valid_q, vid_valid_d, gen_valid_q, gen_valid_d;
  logic                   err_q, err_d;

  logic                   start, gen_wins, deliver, overflow;
  logic [CntW-1:0]        len_plus1;
  logic                   timeout, abort_pulse;

  assign start     = (state_q == IDLE) && (iVidReq || iGenReq);
  assign gen_wins  = iGenReq && (!iVidReq || starve_q == StarveMax);
  assign len_plus1 = {1'b0, len_q} + CntW'(1);
  // A byte arriving once len+1 bytes are already counted is swallowed and flagged.
  assign deliver   = (state_q == STREAM) && iFlValid && (cnt_q != len_plus1);
  assign overflow  = (state_q == STREAM) && iFlValid && (cnt_q == len_plus1);

`ifdef FLASH_ARB_TIMEOUT_EN
  localparam int WdogW = (pTimeout > 1) ? $clog2(pTimeout) : 1;
  logic [WdogW-1:0] wdog_q, wdog_d;
  logic             abort_q;
  logic             in_xfer, progress;

  always_comb begin
    in_xfer  = (state_q == ISSUE) || (state_q == STREAM);
    progress = iFlAck || iFlValid;
    timeout  = in_xfer && !progress && (wdog_q == WdogW'(pTimeout - 1));
    wdog_d   = (!in_xfer || progress) ? '0 : wdog_q + WdogW'(1);
  end

  always_ff @(posedge iSysClk or posedge iRst) begin
    if (iRst) begin
      wdog_q  <= '0;
      abort_q <= 1'b0;
    end else begin
      wdog_q  <= wdog_d;
      abort_q <= timeout;
    end
  end

  assign abort_pulse = abort_q;
`else
  assign timeout     = 1'b0;
  assign abort_pulse = 1'b0;
`endif

  // NOTE: every flop updates with <= so all state samples the same pre-edge values.
  always_ff @(posedge iSysClk or posedge iRst) begin
    if (iRst) begin
      state_q     <= IDLE;
      owner_gen_q <= 1'b0;
      vid_gnt_q   <= 1'b0;
      gen_gnt_q   <= 1'b0;
      addr_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      starve_q    <= '0;
      rd_data_q   <= '0;
      vid_valid_q <= 1'b0;
      gen_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_gen_q <= owner_gen_d;
      vid_gnt_q   <= vid_gnt_d;
      gen_gnt_q   <= gen_gnt_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      rd_data_q   <= rd_data_d;
      vid_valid_q <= vid_valid_d;
      gen_valid_q <= gen_valid_d;
      err_q       <= err_d;
    end
  end

  // NOTE: each always_comb assigns a default first so no path leaves a variable unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (iVidReq || iGenReq) state_d = ISSUE;
      ISSUE:   if (iFlAck)             state_d = STREAM;
      STREAM:  if (iFlDone)            state_d = DONE;
      DONE:                            state_d = IDLE;
      default:                         state_d = IDLE;
    endcase
    if (timeout) state_d = IDLE;
  end

  always_comb begin
    owner_gen_d = owner_gen_q;
    addr_d      = addr_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    starve_d    = starve_q;
    rd_data_d   = rd_data_q;
    vid_gnt_d   = 1'b0;
    gen_gnt_d   = 1'b0;
    vid_valid_d = 1'b0;
    gen_valid_d = 1'b0;
    err_d       = err_q;
    if (start) begin
      owner_gen_d = gen_wins;
      addr_d      = gen_wins ? iGenAddr : iVidAddr;
      len_d       = gen_wins ? iGenLen : iVidLen;
      cnt_d       = '0;
      vid_gnt_d   = !gen_wins;
      gen_gnt_d   = gen_wins;
      if (gen_wins)
        starve_d = '0;
      else if (iGenReq && starve_q != StarveMax)
        starve_d = starve_q + StarveW'(1);
    end
    if (deliver) begin
      cnt_d       = cnt_q + CntW'(1);
      rd_data_d   = iFlData;
      vid_valid_d = !owner_gen_q;
      gen_valid_d = owner_gen_q;
    end
    if (overflow || timeout) err_d = 1'b1;
    if ((state_q == STREAM) && iFlDone && (cnt_d != len_plus1)) err_d = 1'b1;
  end

  always_comb begin
    oBusy     = (state_q != IDLE);
    oFlReq    = (state_q == ISSUE);
    oVidDone  = ((state_q == DONE) || abort_pulse) && !owner_gen_q;
    oGenDone  = ((state_q == DONE) || abort_pulse) && owner_gen_q;
    oFlAbort  = abort_pulse;
    oVidGnt   = vid_gnt_q;
    oGenGnt   = gen_gnt_q;
    oFlAddr   = addr_q;
    oFlLen    = len_q;
    oRdData   = rd_data_q;
    oVidValid = vid_valid_q;
    oGenValid = gen_valid_q;
    oErr      = err_q;
  end

endmodule

// File: tb/tb_qspi_flash_arbiter.sv
// Directed bench for qspi_flash_arbiter (pStarveMax=4, pTimeout=16); inputs change 1ns
// after the rising edge and outputs are compared at the same point.
module tb_qspi_flash_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        vid_req, gen_req;
  logic [23:0] vid_addr, gen_addr;
  logic [9:0]  vid_len, gen_len;
  logic        fl_ack, fl_valid, fl_done;
  logic [7:0]  fl_data;
  logic        vid_gnt, gen_gnt, fl_req, vid_valid, gen_valid;
  logic        vid_done, gen_done, fl_abort, busy, err;
  logic [23:0] fl_addr;
  logic [9:0]  fl_len;
  logic [7:0]  rd_data;

  int n_pass = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  qspi_flash_arbiter #(.pStarveMax(4), .pTimeout(16)) dut (
    .iSysClk(clk), .iRst(rst),
    .iVidReq(vid_req), .iVidAddr(vid_addr), .iVidLen(vid_len),
    .iGenReq(gen_req), .iGenAddr(gen_addr), .iGenLen(gen_len),
    .oVidGnt(vid_gnt), .oGenGnt(gen_gnt),
    .oFlReq(fl_req), .oFlAddr(fl_addr), .oFlLen(fl_len),
    .iFlAck(fl_ack), .iFlData(fl_data), .iFlValid(fl_valid), .iFlDone(fl_done),
    .oRdData(rd_data), .oVidValid(vid_valid), .oGenValid(gen_valid),
    .oVidDone(vid_done), .oGenDone(gen_done), .oFlAbort(fl_abort),
    .oBusy(busy), .oErr(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Single-byte transaction from ISSUE: ack, one byte with done, then back to IDLE.
  task automatic run_xfer(input string tag, input logic gen_owner, input logic [7:0] d);
    fl_ack = 1'b1;
    tick();
    fl_ack = 1'b0;
    check({tag, "_flreq_off"}, fl_req, 0);
    fl_valid = 1'b1; fl_data = d; fl_done = 1'b1;
    tick();
    fl_valid = 1'b0; fl_done = 1'b0;
    check({tag, "_valid"}, {vid_valid, gen_valid}, gen_owner ? 2'b01 : 2'b10);
    check({tag, "_data"}, rd_data, d);
    check({tag, "_done"}, {vid_done, gen_done}, gen_owner ? 2'b01 : 2'b10);
    tick();
    check({tag, "_idle"}, {busy, vid_done, gen_done}, 3'b000);
  endtask

  initial begin
    rst = 1'b1;
    vid_req = 0; gen_req = 0; vid_addr = '0; gen_addr = '0; vid_len = '0; gen_len = '0;
    fl_ack = 0; fl_valid = 0; fl_done = 0; fl_data = '0;
    tick(); tick();
    check("reset_flags", {vid_gnt, gen_gnt, fl_req, vid_valid, gen_valid, vid_done, gen_done,
                          fl_abort, busy, err}, 0);
    check("reset_data", {fl_addr, rd_data}, 0);
    rst = 1'b0;
    tick();

    // 1: video read of 4 bytes at 0x001000
    vid_req = 1; vid_addr = 24'h001000; vid_len = 10'd3;
    tick();
    vid_req = 0;
    check("t1_gnt", {vid_gnt, gen_gnt, fl_req, busy}, 4'b1011);
    check("t1_addr", fl_addr, 24'h001000);
    check("t1_len", fl_len, 3);
    tick();
    check("t1_req_held", {fl_req, vid_gnt}, 2'b10);
    fl_ack = 1;
    tick();
    fl_ack = 0;
    check("t1_stream", {fl_req, busy}, 2'b01);
    for (int i = 0; i < 4; i++) begin
      fl_valid = 1; fl_data = 8'h10 + 8'(i); fl_done = (i == 3);
      tick();
      check("t1_byte_valid", {vid_valid, gen_valid}, 2'b10);
      check("t1_byte_data", rd_data, 8'h10 + 8'(i));
      check("t1_byte_done", vid_done, (i == 3));
    end
    fl_valid = 0; fl_done = 0;
    tick();
    check("t1_end", {vid_valid, vid_done, busy, err}, 4'b0000);

    // 2: simultaneous requests, video first, general after the post-done idle cycle
    vid_req = 1; vid_addr = 24'h002000; vid_len = 0;
    gen_req = 1; gen_addr = 24'h300000; gen_len = 0;
    tick();
    vid_req = 0;
    check("t2_vid_first", {vid_gnt, gen_gnt}, 2'b10);
    check("t2_vid_addr", fl_addr, 24'h002000);
    run_xfer("t2_vid", 1'b0, 8'hA1);
    check("t2_gen_wait", gen_gnt, 0);
    tick();
    gen_req = 0;
    check("t2_gen_gnt", {vid_gnt, gen_gnt}, 2'b01);
    check("t2_gen_addr", fl_addr, 24'h300000);
    run_xfer("t2_gen", 1'b1, 8'hB2);

    // 3: both held high: four video wins, forced general, then video again (starve cleared)
    vid_req = 1; gen_req = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t3_winner", {vid_gnt, gen_gnt}, (i == 4) ? 2'b01 : 2'b10);
      if (i == 5) begin
        vid_req = 0; gen_req = 0;
      end
      run_xfer("t3_xfer", (i == 4), 8'hC0 + 8'(i));
    end

    // 4: general len=1, controller returns 3 bytes
    gen_req = 1; gen_addr = 24'h0000F0; gen_len = 10'd1;
    tick();
    gen_req = 0;
    check("t4_gnt", {vid_gnt, gen_gnt}, 2'b01);
    fl_ack = 1;
    tick();
    fl_ack = 0;
    fl_valid = 1; fl_data = 8'h11;
    tick();
    check("t4_b0", {gen_valid, rd_data, err}, {1'b1, 8'h11, 1'b0});
    fl_data = 8'h22;
    tick();
    check("t4_b1", {gen_valid, rd_data, err}, {1'b1, 8'h22, 1'b0});
    fl_data = 8'h33; fl_done = 1;
    tick();
    fl_valid = 0; fl_done = 0;
    check("t4_b2_dropped", {gen_valid, gen_done, err}, 3'b011);
    tick();
    check("t4_err_sticky", {busy, err}, 2'b01);

    // 5: reset in STREAM clears everything, no done pulse, next request works
    vid_req = 1; vid_addr = 24'h00ABCD; vid_len = 10'd3;
    tick();
    vid_req = 0;
    fl_ack = 1;
    tick();
    fl_ack = 0;
    fl_valid = 1; fl_data = 8'h77;
    tick();
    fl_valid = 0;
    check("t5_mid_byte", vid_valid, 1);
    rst = 1;
    tick();
    check("t5_rst_flags", {vid_gnt, gen_gnt, fl_req, vid_valid, gen_valid, vid_done, gen_done,
                           fl_abort, busy, err}, 0);
    check("t5_rst_data", {fl_addr, fl_len, rd_data}, 0);
    rst = 0;
    tick();
    check("t5_no_done", {vid_done, busy}, 2'b00);
    vid_req = 1; vid_addr = 24'h000040; vid_len = 0;
    tick();
    vid_req = 0;
    check("t5_regnt", {vid_gnt, fl_addr}, {1'b1, 24'h000040});
    run_xfer("t5_xfer", 1'b0, 8'h5A);
    check("t5_err_clear", err, 0);

`ifdef FLASH_ARB_TIMEOUT_EN
    // 6: command never acknowledged: abort after 16 cycles in ISSUE
    vid_req = 1; vid_addr = 24'h000800; vid_len = 0;
    tick();
    vid_req = 0;
    for (int i = 0; i < 15; i++) tick();
    check("t6_pre", {fl_abort, busy, fl_req}, 3'b011);
    tick();
    check("t6_abort", {fl_abort, vid_done, gen_done, err, busy}, 5'b11010);
    tick();
    check("t6_after", {fl_abort, vid_done, busy}, 3'b000);
`else
    // 6: without the watchdog an unacknowledged command waits indefinitely
    vid_req = 1; vid_addr = 24'h000800; vid_len = 0;
    tick();
    vid_req = 0;
    for (int i = 0; i < 20; i++) tick();
    check("t6_wait", {fl_abort, busy, fl_req, err}, 4'b0110);
    run_xfer("t6_xfer", 1'b0, 8'h66);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
